alu_result_stage: RTL

Pipeline stage directly downstream of the 8-bit ALU. It captures each ALU result and its {Z,C,S,O} flags through a valid/ready handshake, buffers them in a 2-entry queue toward register-file writeback, and maintains the architectural status register that feeds the ALU's carry/flag input (`CFlags`). It also resolves conditional branches against the committed status.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/result_fifo2.sv | 37 +++
 rtl/alu_result_stage.sv | 59 +++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared flag layout, condition codes and result entry type for the ALU result stage
package alu_pkg;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_O = 0;
  localparam int RES_DATA_W = 8;
  localparam int RES_REG_AW = 3;
  typedef enum logic [2:0] {
    COND_AL, COND_Z, COND_NZ, COND_C, COND_NC, COND_S, COND_NS, COND_O
  } cond_e;
  typedef struct packed {
    logic [RES_DATA_W-1:0] data;
    logic [RES_REG_AW-1:0] dest;
    logic wen;
    logic taken;
  } result_entry_t;
  function automatic logic cond_true(input logic [3:0] flags, input cond_e cond);
    case (cond)
      COND_Z:  return flags[FLAG_Z];
      COND_NZ: return ~flags[FLAG_Z];
      COND_C:  return flags[FLAG_C];
      COND_NC: return ~flags[FLAG_C];
      COND_S:  return flags[FLAG_S];
      COND_NS: return ~flags[FLAG_S];
      COND_O:  return flags[FLAG_O];
      default: return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/result_fifo2.sv
// result_fifo2: two-entry FIFO of result entries; slot e0 is always the head
module result_fifo2
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  result_entry_t din,
  output result_entry_t head,
  output logic          full,
  output logic          empty
);
  result_entry_t e0, e1;
  logic [1:0] count;
  logic do_push, do_pop;
  assign full    = count == 2'd2;
  assign empty   = count == 2'd0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = e0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
      if (do_pop & full) e0 <= e1;
      else if (do_push & (empty | do_pop)) e0 <= din;
      if (do_push & ~empty & ~do_pop) e1 <= din;
    end
  end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: buffers ALU results toward writeback, keeps the status register and resolves branches
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        in_flags,
  input  logic [3:0]        in_fmask,
  input  logic [REG_AW-1:0] in_dest,
  input  logic              in_wen,
  input  logic              in_branch,
  input  logic [2:0]        in_cond,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_AW-1:0] out_dest,
  output logic              out_wen,
  output logic              out_taken,
  output logic [3:0]        status
);
  result_entry_t entry, head;
  logic full, empty, accept;
  assign in_ready  = ~full & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = ~empty;
  assign out_data  = head.data;
  assign out_dest  = head.dest;
  assign out_wen   = head.wen;
  assign out_taken = head.taken;
  // branches resolve against the status committed before this op's own flag update
  always_comb begin
    entry.data  = in_data;
    entry.dest  = in_dest;
    entry.wen   = in_wen;
    entry.taken = in_branch & cond_true(status, cond_e'(in_cond));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status <= 4'b0000;
    else if (accept) status <= (status & ~in_fmask) | (in_flags & in_fmask);
  end
  result_fifo2 u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (accept),
    .pop  (out_valid & out_ready),
    .flush(flush),
    .din  (entry),
    .head (head),
    .full (full),
    .empty(empty)
  );
endmodule
